// File: rtl/datapath_legv8_mc.sv
// Multicycle LEGv8 datapath: register file, B mux, ALU and data RAM behind a valid/ready FSM.
// Optional program counter output is enabled by defining DATAPATH_LEGV8_PC_EN.
module datapath_legv8_mc #(
    parameter int WIDTH     = 64,
    parameter int NREG      = 32,
    parameter int RAM_DEPTH = 256,
    parameter int DBG_REGS  = 8,
    parameter int DBG_WIDTH = 16,
    localparam int RW = $clog2(NREG),
    localparam int AW = $clog2(RAM_DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cw_valid,
    output logic                          cw_ready,
    input  logic [RW-1:0]                 DA,
    input  logic [RW-1:0]                 SA,
    input  logic [RW-1:0]                 SB,
    input  logic [4:0]                    FS,
    input  logic                          c_in,
    input  logic                          B_sel,
    input  logic [WIDTH-1:0]              k,
    input  logic                          W_reg,
    input  logic                          W_ram,
    input  logic                          MD_sel,
    output logic                          done,
    output logic [WIDTH-1:0]              f,
    output logic [3:0]                    stat,
    output logic [DBG_REGS*DBG_WIDTH-1:0] dbg_regs
`ifdef DATAPATH_LEGV8_PC_EN
    ,
    output logic [WIDTH-1:0]              pc
`endif
);

    typedef struct packed {
        logic [RW-1:0]    da;
        logic [RW-1:0]    sa;
        logic [RW-1:0]    sb;
        logic [4:0]       fs;
        logic             c_in;
        logic             b_sel;
        logic [WIDTH-1:0] k;
        logic             w_reg;
        logic             w_ram;
        logic             md_sel;
    } cw_t;

    typedef enum logic [1:0] {IDLE, EXEC, MEM} state_t;

    localparam logic [RW-1:0] XZR = RW'(NREG - 1);

    state_t           state, state_nx;
    cw_t              cw;
    logic             accept;
    logic             done_nx;
    logic [WIDTH-1:0] regs [NREG];
    logic [WIDTH-1:0] ram [RAM_DEPTH];
    logic [WIDTH-1:0] ram_q;
    logic [WIDTH-1:0] rd_a, rd_b, b_mux;
    logic [WIDTH-1:0] a_p, b_p;
    logic [WIDTH:0]   sum;
    logic [5:0]       sh;
    logic             sh_big;
    logic [WIDTH-1:0] alu_r;
    logic             c_f, v_f;
    logic [AW-1:0]    addr;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;

    assign accept = cw_valid && cw_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (cw_valid) state_nx = EXEC;
            EXEC:    state_nx = cw.md_sel ? MEM : IDLE;
            MEM:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        cw_ready = (state == IDLE);
        done_nx  = (state == MEM) || (state == EXEC && !cw.md_sel);
    end

    // XZR always reads as zero regardless of array contents
    assign rd_a  = (cw.sa == XZR) ? '0 : regs[cw.sa];
    assign rd_b  = (cw.sb == XZR) ? '0 : regs[cw.sb];
    assign b_mux = cw.b_sel ? cw.k : rd_b;

    assign a_p    = cw.fs[1] ? ~rd_a : rd_a;
    assign b_p    = cw.fs[0] ? ~b_mux : b_mux;
    assign sum    = {1'b0, a_p} + {1'b0, b_p} + {{WIDTH{1'b0}}, cw.c_in};
    assign sh     = b_p[5:0];
    assign sh_big = 32'(sh) >= 32'(WIDTH);

    always_comb begin
        alu_r = '0;
        c_f   = 1'b0;
        v_f   = 1'b0;
        case (cw.fs[4:2])
            3'b000: alu_r = a_p & b_p;
            3'b001: alu_r = a_p | b_p;
            3'b010: begin
                alu_r = sum[WIDTH-1:0];
                c_f   = sum[WIDTH];
                v_f   = (a_p[WIDTH-1] == b_p[WIDTH-1]) &&
                        (alu_r[WIDTH-1] != a_p[WIDTH-1]);
            end
            3'b011: alu_r = a_p ^ b_p;
            3'b100: alu_r = sh_big ? '0 : a_p << sh;
            3'b101: alu_r = sh_big ? '0 : a_p >> sh;
            3'b110: alu_r = b_p;
            3'b111: alu_r = a_p;
        endcase
    end

    assign addr = alu_r[AW-1:0];

    always_comb begin
        wr_en   = 1'b0;
        wr_data = alu_r;
        unique case (1'b1)
            (state == EXEC): wr_en = cw.w_reg && !cw.md_sel;
            (state == MEM): begin
                wr_en   = cw.w_reg;
                wr_data = ram_q;
            end
            default: wr_en = 1'b0;
        endcase
        if (cw.da == XZR) wr_en = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cw   <= '0;
            f    <= '0;
            stat <= '0;
            done <= 1'b0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            done <= done_nx;
            if (accept) begin
                cw <= '{da: DA, sa: SA, sb: SB, fs: FS, c_in: c_in,
                        b_sel: B_sel, k: k, w_reg: W_reg,
                        w_ram: W_ram, md_sel: MD_sel};
            end
            if (state == EXEC) begin
                f    <= alu_r;
                stat <= {v_f, c_f, alu_r[WIDTH-1], alu_r == '0};
            end
            if (wr_en) regs[cw.da] <= wr_data;
        end
    end

    // RAM keeps its contents across reset; a load takes priority over a store
    always_ff @(posedge clk) begin
        if (!rst && state == EXEC) begin
            if (cw.md_sel)     ram_q     <= ram[addr];
            else if (cw.w_ram) ram[addr] <= rd_b;
        end
    end

    always_comb begin
        dbg_regs = '0;
        for (int i = 0; i < DBG_REGS; i++)
            dbg_regs[i*DBG_WIDTH +: DBG_WIDTH] = regs[i][DBG_WIDTH-1:0];
    end

`ifdef DATAPATH_LEGV8_PC_EN
    always_ff @(posedge clk) begin
        if (rst)       pc <= '0;
        else if (done) pc <= pc + WIDTH'(4);
    end
`endif

endmodule

// File: tb/tb_datapath_legv8_mc.sv
// Randomized bench for datapath_legv8_mc against an array-based reference model.
// Covers directed plan items, held-valid handshaking, reset aborts and random ops.
module tb_datapath_legv8_mc;

    localparam int W = 64;

    typedef struct {
        logic [4:0]  da, sa, sb, fs;
        logic        ci, bs, wr, wm, md;
        logic [63:0] k;
    } word_t;

    logic         clk = 0;
    logic         rst;
    logic         cw_valid;
    logic         cw_ready;
    logic [4:0]   da, sa, sb, fs;
    logic         c_in, b_sel, w_reg, w_ram, md_sel;
    logic [63:0]  k;
    logic         done;
    logic [63:0]  f;
    logic [3:0]   stat;
    logic [127:0] dbg_regs;
`ifdef DATAPATH_LEGV8_PC_EN
    logic [63:0]  pc;
`endif

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    logic [63:0] mr [32];
    logic [63:0] mram [256];
    logic [63:0] last_r;
    logic [3:0]  last_st;

    datapath_legv8_mc #(
        .WIDTH(64), .NREG(32), .RAM_DEPTH(256), .DBG_REGS(8), .DBG_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst), .cw_valid(cw_valid), .cw_ready(cw_ready),
        .DA(da), .SA(sa), .SB(sb), .FS(fs), .c_in(c_in), .B_sel(b_sel),
        .k(k), .W_reg(w_reg), .W_ram(w_ram), .MD_sel(md_sel),
        .done(done), .f(f), .stat(stat), .dbg_regs(dbg_regs)
`ifdef DATAPATH_LEGV8_PC_EN
        , .pc(pc)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic word_t mk(input logic [4:0] d, s, b, fsv,
                                 input logic ci, bs, input logic [63:0] kk,
                                 input logic wr, wm, md);
        word_t w;
        w.da = d; w.sa = s; w.sb = b; w.fs = fsv; w.ci = ci; w.bs = bs;
        w.k = kk; w.wr = wr; w.wm = wm; w.md = md;
        return w;
    endfunction

    function automatic logic [63:0] rd(input logic [4:0] i);
        return (i == 5'd31) ? 64'd0 : mr[i];
    endfunction

    // Reference ALU from plain arithmetic: exact signed/unsigned sums
    task automatic ref_alu(input logic [4:0] fsv, input logic ci,
                           input logic [63:0] a, b,
                           output logic [63:0] r, output logic [3:0] st);
        logic [63:0] ap, bp;
        logic [64:0] u;
        logic signed [65:0] s;
        logic c, v;
        int sh;
        ap = fsv[1] ? ~a : a;
        bp = fsv[0] ? ~b : b;
        c = 0; v = 0;
        sh = int'(bp[5:0]);
        case (fsv[4:2])
            3'd0: r = ap & bp;
            3'd1: r = ap | bp;
            3'd2: begin
                u = 65'(ap) + 65'(bp) + 65'(ci);
                s = 66'($signed(ap)) + 66'($signed(bp)) + 66'(ci);
                r = u[63:0];
                c = u[64];
                v = (s != 66'($signed(r)));
            end
            3'd3: r = ap ^ bp;
            3'd4: r = (sh >= W) ? 64'd0 : ap << sh;
            3'd5: r = (sh >= W) ? 64'd0 : ap >> sh;
            3'd6: r = bp;
            default: r = ap;
        endcase
        st = {v, c, r[63], r == 64'd0};
    endtask

    task automatic model_apply(input word_t w, output logic [63:0] r,
                               output logic [3:0] st);
        logic [63:0] b, sbv;
        sbv = rd(w.sb);
        b = w.bs ? w.k : sbv;
        ref_alu(w.fs, w.ci, rd(w.sa), b, r, st);
        if (w.md) begin
            if (w.wr && w.da != 5'd31) mr[w.da] = mram[r[7:0]];
        end else begin
            if (w.wr && w.da != 5'd31) mr[w.da] = r;
            if (w.wm) mram[r[7:0]] = sbv;
        end
    endtask

    function automatic logic [127:0] exp_dbg();
        logic [127:0] e;
        for (int i = 0; i < 8; i++) e[i*16 +: 16] = mr[i][15:0];
        return e;
    endfunction

    task automatic drive(input word_t w);
        da = w.da; sa = w.sa; sb = w.sb; fs = w.fs; c_in = w.ci;
        b_sel = w.bs; k = w.k; w_reg = w.wr; w_ram = w.wm; md_sel = w.md;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) mr[i] = 64'd0;
    endtask

    task automatic do_op(input string tag, input word_t w);
        int n, lat;
        @(negedge clk);
        drive(w);
        cw_valid = 1;
        n = 0;
        while (!cw_ready && n < 10) begin @(negedge clk); n++; end
        if (!cw_ready) begin
            check({tag, "_ready"}, 0, 1);
            cw_valid = 0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        cw_valid = 0;
        lat = 0;
        while (!done && lat < 8) begin @(negedge clk); lat++; end
        model_apply(w, last_r, last_st);
        check({tag, "_lat"}, lat, w.md ? 2 : 1);
        check({tag, "_f"}, f, last_r);
        check({tag, "_stat"}, stat, last_st);
        check({tag, "_dbg"}, dbg_regs, exp_dbg());
        @(negedge clk);
        check({tag, "_pulse"}, done, 0);
    endtask

    localparam logic [4:0] ADD = 5'b01000;
    localparam logic [4:0] SUB = 5'b01001;
    localparam logic [4:0] PSA = 5'b11100;

    word_t hs [10];
    time   t_acc [10];

    initial begin
        int n, base;
        word_t w;
        rst = 1; cw_valid = 0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        clear_model();
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        check("rst_ready", cw_ready, 1);
        check("rst_done", done, 0);
        check("rst_f", f, 0);
        check("rst_stat", stat, 0);
        check("rst_dbg", dbg_regs, 0);

        // directed sequence
        do_op("ld_r1", mk(1, 31, 0, ADD, 0, 1, 64'd5, 1, 0, 0));
        do_op("ld_r2", mk(2, 31, 0, ADD, 0, 1, 64'd7, 1, 0, 0));
        do_op("add", mk(3, 1, 2, ADD, 0, 0, 0, 1, 0, 0));
        check("add_r3", dbg_regs[3*16 +: 16], 16'h000C);
        check("add_st", stat, 4'b0000);
        do_op("sub", mk(4, 1, 1, SUB, 1, 0, 0, 1, 0, 0));
        check("sub_st", stat, 4'b0101);
        do_op("ld_max", mk(6, 31, 0, ADD, 0, 1, 64'h7FFF_FFFF_FFFF_FFFF, 1, 0, 0));
        do_op("ovf", mk(7, 6, 0, ADD, 0, 1, 64'd1, 1, 0, 0));
        check("ovf_st", stat, 4'b1010);
        do_op("st", mk(31, 0, 2, ADD, 0, 1, 64'h1FF, 0, 1, 0));
        do_op("ld", mk(5, 31, 0, ADD, 0, 1, 64'hFF, 1, 0, 1));
        check("ld_r5", dbg_regs[5*16 +: 16], 16'd7);
        do_op("xzr_w", mk(31, 31, 0, ADD, 0, 1, 64'd99, 1, 0, 0));
        check("xzr_f", f, 64'd99);
        do_op("xzr_r", mk(8, 31, 0, PSA, 0, 0, 0, 1, 0, 0));
        check("xzr_rd", f, 64'd0);

        // valid held high: accumulate into R6, then load R5 and use it
        hs[0] = mk(6, 31, 0, ADD, 0, 1, 64'($urandom), 1, 0, 0);
        for (int i = 1; i < 8; i++)
            hs[i] = mk(6, 6, 0, ADD, 0, 1, 64'($urandom), 1, 0, 0);
        hs[8] = mk(5, 31, 0, ADD, 0, 1, 64'hFF, 1, 0, 1);
        hs[9] = mk(7, 5, 6, ADD, 0, 0, 0, 1, 0, 0);
        base = done_cnt;
        @(negedge clk);
        drive(hs[0]);
        cw_valid = 1;
        for (int i = 0; i < 10; i++) begin
            n = 0;
            while (!cw_ready && n < 10) begin @(negedge clk); n++; end
            if (!cw_ready) begin
                check("hs_ready", 0, 1);
                break;
            end
            @(posedge clk);
            t_acc[i] = $time;
            if (i > 0)
                check("hs_gap", 128'((t_acc[i] - t_acc[i-1]) / 10),
                      hs[i-1].md ? 3 : 2);
            @(negedge clk);
            if (i < 9) drive(hs[i + 1]);
            else cw_valid = 0;
        end
        n = 0;
        while (!done && n < 8) begin @(negedge clk); n++; end
        @(negedge clk);
        for (int i = 0; i < 10; i++) model_apply(hs[i], last_r, last_st);
        check("hs_count", done_cnt - base, 10);
        check("hs_f", f, last_r);
        check("hs_stat", stat, last_st);
        check("hs_dbg", dbg_regs, exp_dbg());

        // reset during a store's EXEC: RAM must keep its old word
        @(negedge clk);
        drive(mk(31, 31, 1, ADD, 0, 1, 64'hFF, 0, 1, 0));
        cw_valid = 1;
        @(posedge clk);
        @(negedge clk);
        cw_valid = 0;
        rst = 1;
        @(negedge clk);
        rst = 0;
        clear_model();
        check("abst_ready", cw_ready, 1);
        check("abst_dbg", dbg_regs, 0);
        do_op("abst_ld", mk(5, 31, 0, ADD, 0, 1, 64'hFF, 1, 0, 1));

        // reset during a load's MEM cycle
        base = done_cnt;
        @(negedge clk);
        drive(mk(4, 31, 0, ADD, 0, 1, 64'hFF, 1, 0, 1));
        cw_valid = 1;
        @(posedge clk);
        @(negedge clk);
        cw_valid = 0;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        clear_model();
        check("abld_ready", cw_ready, 1);
        @(negedge clk);
        @(negedge clk);
        check("abld_done", done_cnt - base, 0);
        check("abld_dbg", dbg_regs, 0);
`ifdef DATAPATH_LEGV8_PC_EN
        check("pc_rst", pc, 0);
        for (int i = 1; i < 4; i++)
            do_op("pc_op", mk(5'(i), 31, 0, ADD, 0, 1, 64'(i), 1, 0, 0));
        check("pc_12", pc, 12);
`endif

        // random registers, full RAM fill, random ops, readback
        for (int i = 0; i < 31; i++)
            do_op("pre", mk(5'(i), 31, 0, ADD, 0, 1,
                            {$urandom, $urandom}, 1, 0, 0));
        for (int a = 0; a < 256; a++)
            do_op("fill", mk(31, 31, 5'(a % 31), ADD, 0, 1, 64'(a), 0, 1, 0));
        for (int i = 0; i < 150; i++) begin
            w.da = 5'($urandom_range(0, 31));
            w.sa = 5'($urandom_range(0, 31));
            w.sb = 5'($urandom_range(0, 31));
            w.fs = 5'($urandom_range(0, 31));
            w.ci = 1'($urandom_range(0, 1));
            w.bs = 1'($urandom_range(0, 1));
            w.k  = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 300))
                                               : {$urandom, $urandom};
            w.wr = ($urandom_range(0, 3) != 0);
            w.wm = 1'($urandom_range(0, 1));
            w.md = ($urandom_range(0, 2) == 0);
            do_op("rnd", w);
        end
        for (int i = 0; i < 32; i++)
            do_op("rb", mk(31, 5'(i), 0, PSA, 0, 0, 0, 0, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
